// File: rtl/piso_tx5.sv
// -----------------------------------------------------------------------------
// piso_tx5 -- parallel-in serial-out transmitter
//
// Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per clock with valid and last-bit framing. A new word can be taken
// during the last-bit cycle of the current one, so words stream with no gap.
//
// Parameters:
//   WIDTH      word width in bits (2..16)
//   LSB_FIRST  1: bit 0 goes out first, 0: bit WIDTH-1 goes out first
//
// Ports:
//   clock       system clock, all state updates on posedge
//   reset       asynchronous active-high reset
//   i           parallel word, sampled only on an accepted load
//   load_valid  producer offers i this cycle
//   load_ready  transmitter can accept a word this cycle
//   sout        serial data bit (registered, 0 when not valid)
//   sout_valid  sout carries a valid bit (registered)
//   sout_last   sout is the final bit of the word (registered)
//   busy        word in flight, same as sout_valid
// -----------------------------------------------------------------------------
module piso_tx5 #(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       SHIFT    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_r;
    logic [WIDTH-1:0] sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sout_r;
    logic             sout_valid_r;
    logic             sout_last_r;

    logic [0:0]       state_s;
    logic [WIDTH-1:0] sh_s;
    logic [CNT_W-1:0] cnt_s;
    logic             sout_s;
    logic             sout_valid_s;
    logic             sout_last_s;
    logic             load_ready_s;
    logic             accept_s;

    // Handshake: ready when idle or on the last bit, never while reset is held.
    always_comb begin
        load_ready_s = ~reset & ((state_r == IDLE) | sout_last_r);
        accept_s     = load_valid & load_ready_s;
    end

    // Next-state logic. sh holds the whole word; the bit after the one on
    // sout always sits one position in from the output end of sh.
    always_comb begin
        state_s      = state_r;
        sh_s         = sh_r;
        cnt_s        = cnt_r;
        sout_s       = sout_r;
        sout_valid_s = sout_valid_r;
        sout_last_s  = sout_last_r;
        if (accept_s) begin
            state_s      = SHIFT;
            sh_s         = i;
            cnt_s        = {CNT_W{1'b0}};
            sout_s       = LSB_FIRST ? i[0] : i[WIDTH-1];
            sout_valid_s = 1'b1;
            sout_last_s  = ({CNT_W{1'b0}} == CNT_LAST);
        end else begin
            case (state_r)
                SHIFT: begin
                    if (sout_last_r) begin
                        state_s      = IDLE;
                        sh_s         = {WIDTH{1'b0}};
                        cnt_s        = {CNT_W{1'b0}};
                        sout_s       = 1'b0;
                        sout_valid_s = 1'b0;
                        sout_last_s  = 1'b0;
                    end else begin
                        cnt_s        = cnt_r + CNT_W'(1);
                        sout_s       = LSB_FIRST ? sh_r[1] : sh_r[WIDTH-2];
                        sh_s         = LSB_FIRST ? {1'b0, sh_r[WIDTH-1:1]}
                                                 : {sh_r[WIDTH-2:0], 1'b0};
                        sout_valid_s = 1'b1;
                        sout_last_s  = ((cnt_r + CNT_W'(1)) == CNT_LAST);
                    end
                end
                IDLE: begin
                    state_s      = IDLE;
                    sout_s       = 1'b0;
                    sout_valid_s = 1'b0;
                    sout_last_s  = 1'b0;
                end
                default: begin
                    state_s      = IDLE;
                    sh_s         = {WIDTH{1'b0}};
                    cnt_s        = {CNT_W{1'b0}};
                    sout_s       = 1'b0;
                    sout_valid_s = 1'b0;
                    sout_last_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            sh_r         <= {WIDTH{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            sh_r         <= sh_s;
            cnt_r        <= cnt_s;
            sout_r       <= sout_s;
            sout_valid_r <= sout_valid_s;
            sout_last_r  <= sout_last_s;
        end
    end

    assign load_ready = load_ready_s;
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;
    assign busy       = sout_valid_r;

endmodule

// File: tb/tb_piso_tx5.sv
// -----------------------------------------------------------------------------
// tb_piso_tx5 -- self-checking bench for piso_tx5
//
// Two instances share the clock and reset: A (WIDTH=5, LSB first) and
// B (WIDTH=8, MSB first). A word-level reference model tracks, per instance,
// the word in flight, its bit position and the number of bits still to show.
// Directed scenarios are followed by a randomized run with occasional resets.
// -----------------------------------------------------------------------------
module tb_piso_tx5;

    logic       clock;
    logic       reset;
    logic [4:0] i_a;
    logic       lv_a, load_ready_a, sout_a, sout_valid_a, sout_last_a, busy_a;
    logic [7:0] i_b;
    logic       lv_b, load_ready_b, sout_b, sout_valid_b, sout_last_b, busy_b;

    int n_checks;
    int n_fail;

    // Reference model state, index 0 = instance A, 1 = instance B
    int          m_w    [2] = '{5, 8};
    bit          m_lsb  [2] = '{1'b1, 1'b0};
    int          m_rem  [2];
    int          m_pos  [2];
    logic [15:0] m_word [2];

    // Serial bits collected while valid, first bit at index 0
    logic [31:0] acc_a, acc_b;
    int          acc_n_a, acc_n_b;

    piso_tx5 #(.WIDTH(5), .LSB_FIRST(1'b1)) dut_a (
        .clock(clock), .reset(reset), .i(i_a), .load_valid(lv_a),
        .load_ready(load_ready_a), .sout(sout_a), .sout_valid(sout_valid_a),
        .sout_last(sout_last_a), .busy(busy_a)
    );

    piso_tx5 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clock(clock), .reset(reset), .i(i_b), .load_valid(lv_b),
        .load_ready(load_ready_b), .sout(sout_b), .sout_valid(sout_valid_b),
        .sout_last(sout_last_b), .busy(busy_b)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input int d);
        return (reset == 1'b0) && (m_rem[d] <= 1);
    endfunction

    function automatic logic exp_bit(input int d);
        int idx;
        if (m_rem[d] == 0) return 1'b0;
        idx = m_lsb[d] ? m_pos[d] : (m_w[d] - 1 - m_pos[d]);
        return m_word[d][idx];
    endfunction

    task automatic model_step(input int d, input logic acc, input logic [15:0] data);
        if (acc) begin
            m_word[d] = data;
            m_pos[d]  = 0;
            m_rem[d]  = m_w[d];
        end else if (m_rem[d] > 0) begin
            m_rem[d]--;
            m_pos[d]++;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d] = 0;
            m_pos[d] = 0;
        end
    endtask

    task automatic clear_acc();
        acc_a = 32'd0; acc_n_a = 0;
        acc_b = 32'd0; acc_n_b = 0;
    endtask

    task automatic check_outs();
        chk("a_sout",  {31'd0, sout_a},       {31'd0, exp_bit(0)});
        chk("a_valid", {31'd0, sout_valid_a}, {31'd0, m_rem[0] > 0});
        chk("a_last",  {31'd0, sout_last_a},  {31'd0, m_rem[0] == 1});
        chk("a_busy",  {31'd0, busy_a},       {31'd0, m_rem[0] > 0});
        chk("b_sout",  {31'd0, sout_b},       {31'd0, exp_bit(1)});
        chk("b_valid", {31'd0, sout_valid_b}, {31'd0, m_rem[1] > 0});
        chk("b_last",  {31'd0, sout_last_b},  {31'd0, m_rem[1] == 1});
        chk("b_busy",  {31'd0, busy_b},       {31'd0, m_rem[1] > 0});
        if (sout_valid_a === 1'b1 && acc_n_a < 32) begin
            acc_a[acc_n_a] = sout_a;
            acc_n_a++;
        end
        if (sout_valid_b === 1'b1 && acc_n_b < 32) begin
            acc_b[acc_n_b] = sout_b;
            acc_n_b++;
        end
    endtask

    task automatic check_ready();
        chk("a_ready", {31'd0, load_ready_a}, {31'd0, exp_ready(0)});
        chk("b_ready", {31'd0, load_ready_b}, {31'd0, exp_ready(1)});
    endtask

    // One clock: drive at the negedge, check ready, step the model at the
    // posedge, check outputs at the following negedge.
    task automatic cycle(input logic va, input logic [4:0] da,
                         input logic vb, input logic [7:0] db);
        logic acc0, acc1;
        lv_a = va; i_a = da;
        lv_b = vb; i_b = db;
        #1;
        check_ready();
        acc0 = va && exp_ready(0);
        acc1 = vb && exp_ready(1);
        @(posedge clock);
        model_step(0, acc0, {11'd0, da});
        model_step(1, acc1, {8'd0, db});
        @(negedge clock);
        check_outs();
    endtask

    // Reset pulse between clock edges: outputs must clear without an edge.
    task automatic mid_reset();
        lv_a = 1'b0;
        lv_b = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_outs();
        check_ready();
        #1 reset = 1'b0;
        #1;
        check_ready();
        @(posedge clock);
        model_step(0, 1'b0, 16'd0);
        model_step(1, 1'b0, 16'd0);
        @(negedge clock);
        check_outs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        lv_a = 1'b0; i_a = 5'd0;
        lv_b = 1'b0; i_b = 8'd0;
        model_reset();
        clear_acc();

        // Reset state
        #3;
        check_outs();
        check_ready();
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b0, 5'd0, 1'b0, 8'd0);

        // Single word, input changes after accept must not matter
        clear_acc();
        cycle(1'b1, 5'b10110, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 5'($urandom), 1'b0, 8'd0);
        chk("single_n",    acc_n_a, 32'd5);
        chk("single_bits", acc_a,   32'h16);

        // Back-to-back: second word taken in the last-bit cycle
        clear_acc();
        cycle(1'b1, 5'b00001, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 5'b00001, 1'b0, 8'd0);
        cycle(1'b1, 5'b11110, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 5'd0, 1'b0, 8'd0);
        chk("b2b_n",    acc_n_a, 32'd10);
        chk("b2b_bits", acc_a,   32'h3C1);

        // Hold-off: load_valid held from bit 2 until the last-bit cycle
        clear_acc();
        cycle(1'b1, 5'b00000, 1'b0, 8'd0);
        cycle(1'b0, 5'b00000, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 5'b11111, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 5'd0, 1'b0, 8'd0);
        chk("hold_n",    acc_n_a, 32'd10);
        chk("hold_bits", acc_a,   32'h3E0);

        // Mid-word reset, then a clean word
        cycle(1'b1, 5'b10101, 1'b0, 8'd0);
        cycle(1'b0, 5'd0, 1'b0, 8'd0);
        mid_reset();
        clear_acc();
        cycle(1'b1, 5'b01010, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 5'd0, 1'b0, 8'd0);
        chk("rst_n",    acc_n_a, 32'd5);
        chk("rst_bits", acc_a,   32'h0A);

        // MSB first, 8-bit word
        clear_acc();
        cycle(1'b0, 5'd0, 1'b1, 8'hA5);
        for (int k = 0; k < 8; k++) cycle(1'b0, 5'd0, 1'b0, 8'($urandom));
        chk("msb_n",    acc_n_b, 32'd8);
        chk("msb_bits", acc_b,   32'hA5);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 5'($urandom),
                      $urandom_range(0, 3) != 0, 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_tx5.md
Name: piso_tx5

Overview:
- Parallel-in serial-out transmitter: the sending end for the team's 5-bit parallel register path.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a single serial line, with valid and last-bit framing.
- Back-to-back words stream with no idle gap.

Parameters:
WIDTH  5  word width in bits; legal range 2..16
LSB_FIRST  1  1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
i  input  WIDTH  parallel word to transmit; sampled only on an accepted load
load_valid  input  1  producer offers word i this cycle
load_ready  output  1  transmitter can accept a word this cycle
sout  output  1  serial data bit (registered)
sout_valid  output  1  sout carries a valid bit this cycle (registered)
sout_last  output  1  current sout bit is the final bit of the word (registered)
busy  output  1  word in flight; equals sout_valid

Behaviour:
- Decided interface: one clock (clock); reset is asynchronous and active-high (reset).
- State: IDLE, SHIFT. Internal regs: shift register sh[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits).
- Reset (asynchronous, takes effect immediately, independent of clock):
  - state=IDLE, sh=0, cnt=0, sout=0, sout_valid=0, sout_last=0.
  - load_ready is forced 0 while reset is high.
- load_ready (combinational from registers) = ~reset & (state==IDLE | sout_last).
- Accept = load_valid & load_ready at a posedge.
- On accept at edge k:
  - sh captures i; state goes to SHIFT; cnt=0.
  - The same edge drives sout = first bit (i[0] if LSB_FIRST, else i[WIDTH-1]) and sout_valid=1.
  - Load-to-first-bit latency is 0 cycles after the accepting edge.
- In SHIFT, each posedge without a new accept:
  - cnt increments; sh shifts toward the output end.
  - sout presents the next bit.
  - Bit n of the word is visible in the cycle following edge k+n.
- sout_last=1 exactly when cnt==WIDTH-1, i.e. during the final bit cycle.
- Word occupancy: exactly WIDTH consecutive cycles with sout_valid=1.
- End of word (edge after the sout_last cycle):
  - If load_valid=1: new word accepted and its first bit appears immediately. No gap; sout_valid stays 1.
  - Else: state=IDLE, sout_valid=0, sout_last=0, sout=0.
- load_valid while in SHIFT with sout_last=0: ignored, load_ready=0, i not sampled; producer must hold.
- i changing after accept has no effect on the word in flight.
- Reset asserted mid-word: word abandoned, all outputs 0 at once. After release: IDLE, load_ready=1.
- No backpressure on the serial side; the consumer must sample every cycle in which sout_valid=1.
- sout is 0 whenever sout_valid=0.

Test Plan:
- Reset: assert reset mid-cycle with no clock edge -> sout=0, sout_valid=0, sout_last=0, load_ready=0 immediately; release -> load_ready=1.
- Single word, LSB_FIRST=1: i=5'b10110, load_valid pulsed 1 cycle -> sout sequence 0,1,1,0,1 over 5 cycles; sout_valid high 5 cycles; sout_last high only on the 5th bit; then idle.
- Back-to-back: hold load_valid=1 with 5'b00001 then 5'b11110 presented at the sout_last cycle -> 10 contiguous valid bits 1,0,0,0,0,0,1,1,1,1; no gap; second accept occurs in the cycle sout_last=1.
- Hold-off: assert load_valid with 5'b11111 during bit 2 of word 5'b00000 -> load_ready=0; not accepted until the sout_last cycle; first word bits all 0 and uncorrupted.
- Mid-word reset: load 5'b10101; assert reset after 2 bits -> outputs 0 immediately. After release, load 5'b01010 -> clean 0,1,0,1,0.
- LSB_FIRST=0, WIDTH=8: i=8'hA5 -> sout 1,0,1,0,0,1,0,1; sout_last on the 8th bit.
